// File: rtl/sm3_msg_arb.sv
// sm3_msg_arb
//   Round-robin arbiter sharing one SM3 core (pad -> expnd -> cmprss) among
//   N_REQ message sources. A granted requester owns the core for one whole
//   message. The grant is held until that message's 256-bit digest returns,
//   and the digest is then routed back to the owner.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   req_d / req_vld_byte       per-requester word / byte-valid, packed by slot
//   req_vld / req_lst          per-requester word valid / last word of message
//   req_rdy                    word accepted (one-hot or zero)
//   res_d                      last digest, broadcast to all requesters
//   res_vld                    one-cycle digest strobe to the owner
//   msg_inpt_*                 message stream towards the core
//   cmprss_otpt_res / _vld     digest returned by the core
//   busy                       arbiter is not idle
//   owner                      current / last granted requester index
module sm3_msg_arb #(
  parameter  int N_REQ   = 2,
  parameter  int INPT_DW = 32,
  localparam int IDW     = $clog2(N_REQ),
  localparam int BW      = INPT_DW / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ*INPT_DW-1:0] req_d,
  input  logic [N_REQ*BW-1:0]      req_vld_byte,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ-1:0]         req_lst,
  output logic [N_REQ-1:0]         req_rdy,
  output logic [255:0]             res_d,
  output logic [N_REQ-1:0]         res_vld,
  output logic [INPT_DW-1:0]       msg_inpt_d,
  output logic [BW-1:0]            msg_inpt_vld_byte,
  output logic                     msg_inpt_vld,
  output logic                     msg_inpt_lst,
  input  logic                     msg_inpt_rdy,
  input  logic [255:0]             cmprss_otpt_res,
  input  logic                     cmprss_otpt_vld,
  output logic                     busy,
  output logic [IDW-1:0]           owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRM = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [255:0]       res_d_q, res_d_d;
  logic [N_REQ-1:0]   res_vld_q, res_vld_d;

  logic [IDW-1:0]     pick;
  logic               pick_vld;
  logic [IDW-1:0]     owner_inc;
  logic [N_REQ-1:0]   owner_oh;
  logic               xfer;
  logic               xfer_lst;

  logic [INPT_DW-1:0] req_d_a  [N_REQ];
  logic [BW-1:0]      req_vb_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_d_a[g]  = req_d[g*INPT_DW +: INPT_DW];
    assign req_vb_a[g] = req_vld_byte[g*BW +: BW];
  end

  // Round-robin pick: first requester with req_vld set, scanning upward
  // from rr_ptr and wrapping modulo N_REQ.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_w;
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx   = (32'(rr_ptr_q) + k) % N_REQ;
      idx_w = IDW'(idx);
      if (!pick_vld && req_vld[idx_w]) begin
        pick     = idx_w;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    owner_inc         = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    xfer              = (state_q == STRM) && req_vld[owner_q] && msg_inpt_rdy;
    xfer_lst          = xfer && req_lst[owner_q];
  end

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      res_d_q   <= '0;
      res_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      res_d_q   <= res_d_d;
      res_vld_q <= res_vld_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    res_d_d   = res_d_q;
    res_vld_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          state_d = STRM;
        end
      end
      STRM: begin
        if (xfer_lst) begin
          rr_ptr_d = owner_inc;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cmprss_otpt_vld) begin
          res_d_d   = cmprss_otpt_res;
          res_vld_d = owner_oh;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the core bus is a combinational mux from the registered owner;
  // handshake signals are only live while streaming.
  always_comb begin
    msg_inpt_d        = req_d_a[owner_q];
    msg_inpt_vld_byte = req_vb_a[owner_q];
    msg_inpt_vld      = 1'b0;
    msg_inpt_lst      = 1'b0;
    req_rdy           = '0;
    if (state_q == STRM) begin
      msg_inpt_vld = req_vld[owner_q];
      msg_inpt_lst = req_lst[owner_q];
      req_rdy      = owner_oh & {N_REQ{msg_inpt_rdy}};
    end
    busy    = (state_q != IDLE);
    owner   = owner_q;
    res_d   = res_d_q;
    res_vld = res_vld_q;
  end

endmodule

// File: tb/tb_sm3_msg_arb.sv
// tb_sm3_msg_arb
//   Scoreboard bench for sm3_msg_arb with two requesters and a small core
//   model. Expected core words are queued in planned grant order when a
//   message is enqueued; expected digests are queued when the core model
//   returns one.
module tb_sm3_msg_arb;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = $clog2(NR);

  typedef struct { logic [DW-1:0] d; logic [BW-1:0] vb; logic lst; } word_t;
  typedef struct { logic [DW-1:0] d; logic [BW-1:0] vb; logic lst; int own; } xfer_t;
  typedef struct { int own; logic [255:0] dig; int cyc; } res_t;
  typedef struct { int gap; int span; } log_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*DW-1:0] req_d = '0;
  logic [NR*BW-1:0] req_vld_byte = '0;
  logic [NR-1:0]    req_vld = '0;
  logic [NR-1:0]    req_lst = '0;
  logic [NR-1:0]    req_rdy;
  logic [255:0]     res_d;
  logic [NR-1:0]    res_vld;
  logic [DW-1:0]    msg_inpt_d;
  logic [BW-1:0]    msg_inpt_vld_byte;
  logic             msg_inpt_vld;
  logic             msg_inpt_lst;
  logic             msg_inpt_rdy = 1'b1;
  logic [255:0]     cmprss_otpt_res = '0;
  logic             cmprss_otpt_vld = 1'b0;
  logic             busy;
  logic [IW-1:0]    owner;

  sm3_msg_arb #(.N_REQ(NR), .INPT_DW(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_d             (req_d),
    .req_vld_byte      (req_vld_byte),
    .req_vld           (req_vld),
    .req_lst           (req_lst),
    .req_rdy           (req_rdy),
    .res_d             (res_d),
    .res_vld           (res_vld),
    .msg_inpt_d        (msg_inpt_d),
    .msg_inpt_vld_byte (msg_inpt_vld_byte),
    .msg_inpt_vld      (msg_inpt_vld),
    .msg_inpt_lst      (msg_inpt_lst),
    .msg_inpt_rdy      (msg_inpt_rdy),
    .cmprss_otpt_res   (cmprss_otpt_res),
    .cmprss_otpt_vld   (cmprss_otpt_vld),
    .busy              (busy),
    .owner             (owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  word_t stim_q [NR][$];
  xfer_t exp_core [$];
  res_t  exp_res [$];
  log_t  msg_log [$];

  // requester / core model configuration
  int bub_word [NR] = '{-1, -1};
  int bub_left [NR] = '{0, 0};
  int wi       [NR] = '{0, 0};
  bit bub_done [NR] = '{0, 0};
  int stall_word = -1;
  int stall_left = 0;
  int core_wi    = 0;
  bit stalled    = 0;
  int dig_wait   = 0;
  int dig_own    = 0;
  int msg_no     = 0;
  int spur_req   = 0;
  int spur_done  = 0;

  // monitor state
  logic [NR-1:0] took = '0;
  bit xfer_seen     = 0;
  bit xfer_lst_seen = 0;
  int xfer_own      = 0;
  int cyc           = 0;
  bit in_msg        = 0;
  int first_cyc     = 0;
  int last_res_cyc  = 0;
  int cur_gap       = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic enq_word(input int r, input logic [DW-1:0] d, input logic lst);
    word_t w;
    xfer_t x;
    w.d   = d;
    w.lst = lst;
    w.vb  = lst ? BW'({d[2:0], 1'b1}) : '1;
    stim_q[r].push_back(w);
    x.d   = w.d;
    x.vb  = w.vb;
    x.lst = w.lst;
    x.own = r;
    exp_core.push_back(x);
  endtask

  task automatic enq_msg(input int r, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) enq_word(r, base + DW'(i), (i == n - 1));
  endtask

  task automatic chk_reset(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_owner"}, owner, 0);
    check({pfx, "_req_rdy"}, req_rdy, 0);
    check({pfx, "_core_vld"}, msg_inpt_vld, 0);
    check({pfx, "_core_lst"}, msg_inpt_lst, 0);
    check({pfx, "_res_vld"}, res_vld, 0);
    check({pfx, "_res_d"}, res_d, 0);
  endtask

  task automatic do_reset(input string pfx);
    rst_n = 1'b0;
    #1;
    chk_reset(pfx);
    for (int r = 0; r < NR; r++) stim_q[r].delete();
    exp_core.delete();
    exp_res.delete();
    msg_log.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    int pend;
    n    = 0;
    pend = exp_core.size() + exp_res.size() + int'(busy);
    while (pend != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      pend = exp_core.size() + exp_res.size() + int'(busy);
    end
    check({tag, "_drain"}, pend, 0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_log(input string tag, input int i, input int gap_exp, input int span_exp);
    if (i >= msg_log.size()) begin
      check({tag, "_logged"}, msg_log.size(), i + 1);
    end else begin
      if (gap_exp >= 0) check({tag, "_gap"}, msg_log[i].gap, gap_exp);
      check({tag, "_span"}, msg_log[i].span, span_exp);
    end
  endtask

  // Requester and core models: drive inputs 1 time unit after each rising edge
  // based on handshakes sampled on the preceding falling edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req_vld         = '0;
      req_lst         = '0;
      req_d           = '0;
      req_vld_byte    = '0;
      msg_inpt_rdy    = 1'b1;
      cmprss_otpt_vld = 1'b0;
      for (int r = 0; r < NR; r++) begin
        wi[r]       = 0;
        bub_left[r] = 0;
        bub_done[r] = 0;
      end
      core_wi    = 0;
      stalled    = 0;
      stall_left = 0;
      dig_wait   = 0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (took[r] && stim_q[r].size() > 0) begin
          if (stim_q[r][0].lst) begin
            wi[r]       = 0;
            bub_done[r] = 0;
          end else begin
            wi[r]++;
          end
          void'(stim_q[r].pop_front());
        end
        if (stim_q[r].size() > 0 && !bub_done[r] && wi[r] == bub_word[r]) begin
          bub_left[r] = 2;
          bub_done[r] = 1;
        end
        if (bub_left[r] > 0) begin
          bub_left[r]--;
          req_vld[r] = 1'b0;
        end else if (stim_q[r].size() > 0) begin
          req_vld[r]             = 1'b1;
          req_d[r*DW +: DW]      = stim_q[r][0].d;
          req_vld_byte[r*BW +: BW] = stim_q[r][0].vb;
          req_lst[r]             = stim_q[r][0].lst;
        end else begin
          req_vld[r] = 1'b0;
          req_lst[r] = 1'b0;
        end
      end

      if (xfer_seen) begin
        if (xfer_lst_seen) begin
          core_wi  = 0;
          stalled  = 0;
          dig_wait = 3;
          dig_own  = xfer_own;
        end else begin
          core_wi++;
        end
      end
      if (!stalled && stall_word >= 0 && core_wi == stall_word) begin
        stall_left = 5;
        stalled    = 1;
      end
      if (stall_left > 0) begin
        msg_inpt_rdy = 1'b0;
        stall_left--;
      end else begin
        msg_inpt_rdy = 1'b1;
      end

      cmprss_otpt_vld = 1'b0;
      if (dig_wait > 0) begin
        dig_wait--;
        if (dig_wait == 0) begin
          res_t e;
          cmprss_otpt_vld = 1'b1;
          cmprss_otpt_res = {8{32'(32'hC0DE0000 + 32'(msg_no) * 32'h01010101)}};
          e.own = dig_own;
          e.dig = cmprss_otpt_res;
          e.cyc = cyc + 2;
          exp_res.push_back(e);
          msg_no++;
        end
      end else if (spur_done != spur_req) begin
        spur_done++;
        cmprss_otpt_vld = 1'b1;
        cmprss_otpt_res = {8{32'($urandom)}};
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    xfer_t it;
    res_t  rr;
    log_t  lg;
    cyc++;
    took          = '0;
    xfer_seen     = 0;
    xfer_lst_seen = 0;
    if (!rst_n) begin
      in_msg = 0;
    end else begin
      took = req_vld & req_rdy;
      if (exp_core.size() > 0) check("rdy_nonowner", req_rdy & ~onehot(exp_core[0].own), 0);
      else check("rdy_idle", req_rdy, 0);
      if (msg_inpt_vld && msg_inpt_rdy) begin
        if (exp_core.size() == 0) begin
          check("xfer_unexpected", 1, 0);
        end else begin
          it = exp_core.pop_front();
          check("core_d", msg_inpt_d, it.d);
          check("core_vb", msg_inpt_vld_byte, it.vb);
          check("core_lst", msg_inpt_lst, it.lst);
          check("owner", owner, it.own);
          check("rdy_onehot", req_rdy, onehot(it.own));
          check("busy_strm", busy, 1);
          xfer_seen     = 1;
          xfer_lst_seen = it.lst;
          xfer_own      = it.own;
          if (!in_msg) begin
            in_msg    = 1;
            first_cyc = cyc;
            cur_gap   = cyc - last_res_cyc;
          end
          if (it.lst) begin
            lg.gap  = cur_gap;
            lg.span = cyc - first_cyc;
            msg_log.push_back(lg);
            in_msg = 0;
          end
        end
      end
      if (res_vld != '0) begin
        if (exp_res.size() == 0) begin
          check("res_unexpected", res_vld, 0);
        end else begin
          rr = exp_res.pop_front();
          check("res_vld", res_vld, onehot(rr.own));
          check("res_d", res_d, rr.dig);
          check("res_latency", cyc, rr.cyc);
        end
        last_res_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #3;
    chk_reset("rst0");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 1: single 3-word message from req0
    enq_word(0, 32'h61626380, 1'b0);
    enq_word(0, 32'h00000000, 1'b0);
    enq_word(0, 32'h00000018, 1'b1);
    wait_drain("t1", 200);
    chk_log("t1", 0, -1, 2);

    // 2: simultaneous requests from reset, req0 wins then req1
    do_reset("rst1");
    enq_msg(0, 3, 32'h100);
    enq_msg(1, 2, 32'h200);
    wait_drain("t2", 300);
    chk_log("t2m0", 0, -1, 2);
    chk_log("t2m1", 1, 1, 1);

    // 3: continuous requests, grant order 0,1,0,1
    msg_log.delete();
    enq_msg(0, 2, 32'h300);
    enq_msg(1, 2, 32'h310);
    enq_msg(0, 2, 32'h320);
    enq_msg(1, 2, 32'h330);
    wait_drain("t3", 400);
    chk_log("t3m1", 1, 1, 1);
    chk_log("t3m2", 2, 1, 1);
    chk_log("t3m3", 3, 1, 1);

    // 4: core stall of 5 cycles after word 2, 2-cycle bubble before word 4
    msg_log.delete();
    stall_word  = 2;
    bub_word[0] = 4;
    enq_msg(0, 6, 32'h400);
    enq_msg(1, 2, 32'h410);
    wait_drain("t4", 300);
    chk_log("t4m0", 0, -1, 12);
    chk_log("t4m1", 1, 1, 1);
    stall_word  = -1;
    bub_word[0] = -1;

    // 5: spurious digest strobes in IDLE and in STRM
    msg_log.delete();
    spur_req++;
    repeat (6) @(negedge clk);
    #1;
    check("t5_idle_busy", busy, 0);
    stall_word = 1;
    enq_msg(1, 3, 32'h500);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_grant", busy, 1);
    @(posedge clk);
    #2;
    spur_req++;
    repeat (3) @(negedge clk);
    #1;
    check("t5_strm_busy", busy, 1);
    check("t5_strm_owner", owner, 1);
    wait_drain("t5", 300);
    chk_log("t5m0", 0, -1, 7);
    stall_word = -1;

    // 6: reset in the middle of a req1 message
    msg_log.delete();
    enq_msg(1, 4, 32'h600);
    n = 0;
    while (exp_core.size() > 2 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_two_words", exp_core.size(), 2);
    @(posedge clk);
    #2;
    check("t6_pre_owner", owner, 1);
    check("t6_pre_busy", busy, 1);
    do_reset("t6_rst");
    enq_msg(1, 2, 32'h610);
    wait_drain("t6", 200);
    chk_log("t6m0", 0, -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
